// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES types and GF(2^8) helpers for the SIMD AES datapath.
//   byte_t / column_t / state_t : byte, 32-bit column and 128-bit state types
//   inv_fsm_t                   : control states of the decrypt stage
//   xtime(), gf_mul()           : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
//   inv_shift_rows()            : InvShiftRows on a column-major state
// State layout: byte k = state[127-8k -: 8], row = k%4, col = k/4.
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  column_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } inv_fsm_t;

  // Low byte of the reduction polynomial 0x11B; the x^8 term is implicit.
  localparam byte_t GF_POLY = 8'h1B;

  // Multiply by x in GF(2^8).
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (0x09/0x0B/0x0D/0x0E for InvMixColumns)
  // as a shift-and-add over the constant's bits.
  function automatic byte_t gf_mul(input byte_t b, input logic [3:0] k);
    byte_t p;
    byte_t acc;
    p   = b;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Row r is rotated right by r bytes: out(r,c) = in(r,(c-r) mod 4).
  function automatic state_t inv_shift_rows(input state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c - row + 4) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// -----------------------------------------------------------------------------
// inv_mix_column
// Combinational InvMixColumns of one 32-bit column.
//   col_i : input column, row 0 in bits [31:24]
//   col_o : transformed column, same byte order
// out_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3), indices mod 4.
// -----------------------------------------------------------------------------
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  byte_t a [4];

  // NOTE: every combinational output gets a default before any conditional
  // or looped assignment, so no path can leave it unassigned (no latch).
  always_comb begin
    col_o = '0;
    for (int r = 0; r < 4; r++) a[r] = col_i[31 - 8*r -: 8];
    for (int r = 0; r < 4; r++) begin
      col_o[31 - 8*r -: 8] = gf_mul(a[r],           4'hE) ^
                             gf_mul(a[(r + 1) % 4], 4'hB) ^
                             gf_mul(a[(r + 2) % 4], 4'hD) ^
                             gf_mul(a[(r + 3) % 4], 4'h9);
    end
  end

endmodule

// File: rtl/inv_shift_mix_unit.sv
// -----------------------------------------------------------------------------
// inv_shift_mix_unit
// Decrypt-side stage: InvShiftRows on accept, then InvMixColumns iterated over
// COLS_PER_CYCLE columns per cycle, with valid/ready on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : upstream handshake (ready only in IDLE)
//   state_in, skip_mix  : input state; skip_mix=1 bypasses InvMixColumns
//   round_key           : (INV_ADDKEY_EN only) XORed after InvShiftRows
//   out_valid/out_ready : downstream handshake
//   state_out           : working register, meaningful while out_valid=1
//   busy                : high whenever not IDLE
// Build option: define INV_ADDKEY_EN to add the round_key input.
// Parameter COLS_PER_CYCLE: 1, 2 or 4.
// -----------------------------------------------------------------------------
module inv_shift_mix_unit
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         skip_mix,
`ifdef INV_ADDKEY_EN
  input  logic [127:0] round_key,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_shift_mix_unit: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  // Counter value at which the final group of columns is processed.
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  inv_fsm_t   fsm_q,   fsm_d;
  logic [1:0] cnt_q,   cnt_d;
  state_t     state_q, state_d;
  state_t     loaded;

  logic [1:0]  col_idx [COLS_PER_CYCLE];
  column_t     mix_in  [COLS_PER_CYCLE];
  column_t     mix_out [COLS_PER_CYCLE];

  // Column c lives at bits [32*(3-c) +: 32]; ~c == 3-c for a 2-bit index.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
    assign col_idx[g] = cnt_q + 2'(g);
    assign mix_in[g]  = state_q[{~col_idx[g], 5'b0} +: 32];
    inv_mix_column u_col (
      .col_i (mix_in[g]),
      .col_o (mix_out[g])
    );
  end

`ifdef INV_ADDKEY_EN
  // Equivalent-decryption order: key added before InvMixColumns.
  assign loaded = inv_shift_rows(state_in) ^ round_key;
`else
  assign loaded = inv_shift_rows(state_in);
`endif

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = loaded;
          cnt_d   = '0;
          fsm_d   = skip_mix ? DONE : MIX;
        end
      end
      MIX: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          state_d[{~col_idx[g], 5'b0} +: 32] = mix_out[g];
        end
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == LAST_CNT) fsm_d = DONE;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      // NOTE: the working register is reset too, because state_out must read
      // zero after reset and an aborted operation must not leak out.
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Gated by rst so that the unit never advertises ready in the reset cycle.
  assign in_ready  = (fsm_q == IDLE) && !rst;
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign state_out = state_q;

endmodule

// File: tb/tb_inv_shift_mix_unit.sv
// -----------------------------------------------------------------------------
// tb_inv_shift_mix_unit
// Three instances (COLS_PER_CYCLE = 1, 2, 4) share the inputs; each has its
// own outputs. Directed vectors with hand-computed results.
// -----------------------------------------------------------------------------
module tb_inv_shift_mix_unit;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] state_in;
  logic         skip_mix;
  logic         out_ready;
`ifdef INV_ADDKEY_EN
  logic [127:0] round_key;
`endif

  logic         rdy [3];
  logic         ov  [3];
  logic [127:0] so  [3];
  logic         bz  [3];

  int checks = 0;
  int errors = 0;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    inv_shift_mix_unit #(.COLS_PER_CYCLE(1 << i)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (rdy[i]),
      .state_in  (state_in),
      .skip_mix  (skip_mix),
`ifdef INV_ADDKEY_EN
      .round_key (round_key),
`endif
      .out_valid (ov[i]),
      .out_ready (out_ready),
      .state_out (so[i]),
      .busy      (bz[i])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; skip_mix = 1'b0; state_in = '0;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (rdy[i] !== 1'b0) begin errors++; $display("FAIL reset_in_ready dut%0d: got %b want 0", i, rdy[i]); end
      checks++; if (ov[i]  !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d: got %b want 0", i, ov[i]); end
      checks++; if (so[i]  !== '0)   begin errors++; $display("FAIL reset_state_out dut%0d: got %h want 0", i, so[i]); end
      checks++; if (bz[i]  !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b want 0", i, bz[i]); end
    end
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (rdy[i] !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready dut%0d: got %b want 1", i, rdy[i]); end
    end
  endtask

  // Issues one op to all instances with out_ready=1 and checks each
  // instance's latency (accept edge counted as 1) and result.
  task automatic run_op(input string name, input logic [127:0] din,
                        input logic skip, input logic [127:0] expected);
    int           lat [3];
    logic [127:0] got [3];
    int           exp_lat;
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1; got[i] = 'x;
      checks++; if (rdy[i] !== 1'b1) begin errors++; $display("FAIL %s_ready dut%0d: got %b want 1", name, i, rdy[i]); end
    end
    state_in = din; skip_mix = skip; out_ready = 1'b1; in_valid = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step();
      if (n == 0) in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (ov[i] === 1'b1 && lat[i] < 0) begin
          lat[i] = n + 1;
          got[i] = so[i];
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      exp_lat = skip ? 1 : 1 + 4 / (1 << i);
      checks++; if (lat[i] !== exp_lat) begin errors++; $display("FAIL %s_latency dut%0d: got %0d want %0d", name, i, lat[i], exp_lat); end
      checks++; if (got[i] !== expected) begin errors++; $display("FAIL %s_data dut%0d: got %h want %h", name, i, got[i], expected); end
    end
  endtask

  task automatic test_mix_vectors();
    run_op("identity", {4{32'h8e4da1bc}}, 1'b0, {4{32'hdb135345}});
    run_op("known",    {4{32'h9fdc589d}}, 1'b0, {4{32'hf20a225c}});
    run_op("zero",     '0,                1'b0, '0);
    run_op("ones",     {4{32'h01010101}}, 1'b0, {4{32'h01010101}});
    // Distinct columns after InvShiftRows exercise the column indexing.
    run_op("mixed", 128'h8edc0100_9f0100bc_0100a19d_004d5801, 1'b0,
           128'hdb135345_f20a225c_01010101_00000000);
  endtask

  task automatic test_skip_mix();
    run_op("skip", 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1,
           128'h000d0a07_04010e0b_0805020f_0c090603);
  endtask

`ifdef INV_ADDKEY_EN
  task automatic test_addkey();
    round_key = '1;
    run_op("addkey", 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1,
           128'hfff2f5f8_fbfef1f4_f7fafdf0_f3f6f9fc);
    round_key = '0;
  endtask
`endif

  task automatic test_backpressure();
    logic [127:0] exp_data;
    logic         all_v;
    exp_data  = {4{32'hf20a225c}};
    out_ready = 1'b0;
    state_in  = {4{32'h9fdc589d}}; skip_mix = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    all_v = 1'b0;
    for (int n = 0; n < 10 && !all_v; n++) begin
      all_v = ov[0] && ov[1] && ov[2];
      if (!all_v) step();
    end
    checks++; if (all_v !== 1'b1) begin errors++; $display("FAIL bp_reach_done: got %b want 1", all_v); end
    for (int n = 0; n < 10; n++) begin
      // Offer a different op while not ready; it must be ignored.
      if (n == 3) begin in_valid = 1'b1; state_in = {4{32'h01010101}}; end
      if (n == 6) in_valid = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
        checks++; if (so[i]  !== exp_data) begin errors++; $display("FAIL bp_hold_data dut%0d: got %h want %h", i, so[i], exp_data); end
        checks++; if (ov[i]  !== 1'b1) begin errors++; $display("FAIL bp_hold_valid dut%0d: got %b want 1", i, ov[i]); end
        checks++; if (rdy[i] !== 1'b0) begin errors++; $display("FAIL bp_hold_ready dut%0d: got %b want 0", i, rdy[i]); end
        checks++; if (bz[i]  !== 1'b1) begin errors++; $display("FAIL bp_hold_busy dut%0d: got %b want 1", i, bz[i]); end
      end
    end
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (ov[i]  !== 1'b0) begin errors++; $display("FAIL bp_release_valid dut%0d: got %b want 0", i, ov[i]); end
      checks++; if (rdy[i] !== 1'b1) begin errors++; $display("FAIL bp_release_ready dut%0d: got %b want 1", i, rdy[i]); end
    end
    // out_ready high while idle has no effect; state_out keeps its value.
    step(); step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bz[i] !== 1'b0) begin errors++; $display("FAIL idle_busy dut%0d: got %b want 0", i, bz[i]); end
      checks++; if (so[i] !== exp_data) begin errors++; $display("FAIL idle_retain dut%0d: got %h want %h", i, so[i], exp_data); end
    end
  endtask

  task automatic test_reset_mid_mix();
    logic seen;
    out_ready = 1'b1;
    state_in = {4{32'h8e4da1bc}}; skip_mix = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (bz[0] !== 1'b1) begin errors++; $display("FAIL mid_mix_busy dut0: got %b want 1", bz[0]); end
    rst = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (ov[i]  !== 1'b0) begin errors++; $display("FAIL abort_valid dut%0d: got %b want 0", i, ov[i]); end
      checks++; if (so[i]  !== '0)   begin errors++; $display("FAIL abort_state_out dut%0d: got %h want 0", i, so[i]); end
      checks++; if (bz[i]  !== 1'b0) begin errors++; $display("FAIL abort_busy dut%0d: got %b want 0", i, bz[i]); end
      checks++; if (rdy[i] !== 1'b0) begin errors++; $display("FAIL abort_in_ready dut%0d: got %b want 0", i, rdy[i]); end
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (ov[0] || ov[1] || ov[2]) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_output: got %b want 0", seen); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rdy[i] !== 1'b1) begin errors++; $display("FAIL abort_recover_ready dut%0d: got %b want 1", i, rdy[i]); end
    end
  endtask

  initial begin
`ifdef INV_ADDKEY_EN
    round_key = '0;
`endif
    test_reset();
    test_mix_vectors();
    test_skip_mix();
`ifdef INV_ADDKEY_EN
    test_addkey();
`endif
    test_backpressure();
    test_reset_mid_mix();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_shift_mix_unit.md
Name: inv_shift_mix_unit

Overview:
Multi-cycle decrypt-side datapath stage: InvShiftRows, then iterative InvMixColumns, one or more columns per cycle. Inverse counterpart of the forward ShiftRows logic in the execute stage, for the SIMD AES decrypt instruction path. Uses a valid/ready handshake on both sides. State layout matches the forward path: column-major, byte k = state[127-8k -: 8], row = k%4, col = k/4.

Parameters:
COLS_PER_CYCLE, 1, InvMixColumns columns processed per cycle; legal values 1, 2, 4 (elaboration error otherwise).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream state valid
in_ready  output  1  unit can accept (high only in IDLE)
state_in  input  128  input state, column-major
skip_mix  input  1  sampled with state_in; 1 = final decrypt round, no InvMixColumns
out_valid  output  1  state_out valid
out_ready  input  1  downstream accepts
state_out  output  128  result state
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: in_ready=0 during the reset cycle and 1 afterwards. out_valid=0, state_out=0, busy=0. FSM=IDLE, column counter=0.
- Reset mid-operation aborts immediately. The in-flight state is discarded and no out_valid is produced.
- FSM states: IDLE, MIX, DONE.
- IDLE:
  - On in_valid&in_ready, register InvShiftRows(state_in).
  - Output (r,c) = input (r,(c-r) mod 4), i.e. row r rotated right by r bytes. Example: out byte1 = in byte13, out byte2 = in byte10, out byte3 = in byte7.
  - If skip_mix=1, go to DONE; otherwise go to MIX with the column counter at 0.
- MIX:
  - Each cycle, replace columns [cnt, cnt+COLS_PER_CYCLE-1] with InvMixColumns of those columns.
  - cnt += COLS_PER_CYCLE. When the last column is written, go to DONE.
- InvMixColumns arithmetic:
  - GF(2^8) with polynomial 0x11B.
  - Per column: out_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3), indices mod 4.
  - All byte ops are 8-bit, with no carries outside a byte.
- DONE:
  - out_valid=1 and state_out is the working register.
  - state_out is held stable while out_valid&!out_ready.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency from the accept edge to out_valid high: 1 + 4/COLS_PER_CYCLE cycles (5/3/2); 1 cycle when skip_mix=1.
- Throughput: in_ready is low in MIX and DONE, so there is no overlap. Back-to-back throughput is one op per (latency+1) cycles.
- in_valid while not ready: ignored. Upstream must hold its data until accepted.
- out_ready asserted while out_valid=0: no effect.
- state_out between operations: retains its last value. It is meaningful only while out_valid=1.

Optional Feature:
INV_ADDKEY_EN
- Defined:
  - Adds port round_key (input, 128), sampled together with state_in.
  - The loaded value becomes InvShiftRows(state_in) ^ round_key, applied before InvMixColumns, in equivalent-decryption order.
  - The XOR is also applied when skip_mix=1.
- Undefined: round_key port absent; no XOR. Latency is identical in both builds.

Decomposition:
- Shared package aes_pkg:
  - byte_t and state_t (logic [127:0]) typedefs.
  - inv_fsm_t enum {IDLE, MIX, DONE}.
  - GF_POLY = 8'h1B.
  - Functions xtime() and gf_mul(byte_t, 4-bit const).
  - inv_shift_rows() function, reusable by the forward path's tests.
- One sub-module, inv_mix_column: combinational, 32-bit column in and out. Instantiated COLS_PER_CYCLE times.

Test Plan:
- Identity check: state_in = column {8e,4d,a1,bc} repeated ×4, skip_mix=0 → after 5 cycles state_out = {db,13,53,45} ×4.
- Known vector: column {9f,dc,58,9d} ×4 → {f2,0a,22,5c} ×4. Also all-zero → zero, and {01,01,01,01} ×4 → unchanged.
- skip_mix=1 with state_in = 00 01 02 … 0f → 1 cycle later state_out = 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → state_out stable, in_ready=0, busy=1. Release → out_valid falls next cycle and in_ready=1.
- Reset mid-MIX at cycle 2 → next cycle out_valid=0, state_out=0, FSM=IDLE; the aborted op never appears at the output.
- Run the first two scenarios with COLS_PER_CYCLE=2 and 4 (latency 3 and 2) and with INV_ADDKEY_EN defined, round_key = all-ff, skip_mix=1 → state_out = InvShiftRows(state_in) ^ ff…ff.
